vrf_operand_fetch: RTL and testbench
====================================

# vrf_operand_fetch

Operand-fetch stage on the read side of the vector register file. It accepts issued vector micro-ops and drives three VRF read addresses. It captures the returned source vectors into an output register slice, and hands the operand bundle to the execution lanes over a valid/ready handshake. A per-register scoreboard is set at issue and cleared by observed VRF write ports, and it blocks RAW and WAW hazards.

## Interface
Parameters:
- NUM_REG, 32, number of vector registers; ADDRESS = $clog2(NUM_REG)
- DATA_SIZE, 2048, vector datapath width
- NUM_WB, 8, number of VRF write ports observed for scoreboard clear
- UOP_W, 32, opaque micro-op payload width

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous, active-low reset
- iss_valid  in  1  issue request valid
- iss_ready  out  1  issue request accepted this cycle when high with iss_valid
- iss_vs  in  ADDRESS x3  source register addresses [0]=vs1, [1]=vs2, [2]=vs3
- iss_src_en  in  3  per-source enable
- iss_vd  in  ADDRESS  destination register
- iss_vd_en  in  1  micro-op writes iss_vd
- iss_uop  in  UOP_W  payload, passed through
- rd_addr  out  ADDRESS x3  to VRF read ports 0..2, equal to iss_vs combinationally
- rd_data  in  DATA_SIZE x3  from VRF (combinational read)
- wb_en  in  NUM_WB  copy of VRF write enables
- wb_addr  in  ADDRESS x NUM_WB  copy of VRF write addresses
- op_valid  out  1  operand bundle valid
- op_ready  in  1  execution lanes accept bundle
- op_data  out  DATA_SIZE x3  captured source vectors
- op_vd, op_vd_en, op_uop  out  ADDRESS/1/UOP_W  registered pass-through
- sb_pending  out  NUM_REG  scoreboard state
- stall_cnt  out  16  hazard-stall cycle counter

## Operation
- hazard = OR over enabled sources k of sb_pending[iss_vs[k]], OR (iss_vd_en AND sb_pending[iss_vd]).
- hazard uses the registered scoreboard only. A bit being cleared this cycle still counts as a hazard.
- iss_ready = !hazard AND (!op_valid OR op_ready). This path is combinational from op_ready.
- Accept (iss_valid AND iss_ready) has these effects:
  - op_data[k] <= rd_data[k] if iss_src_en[k], else 0.
  - op_vd, op_vd_en and op_uop are loaded.
  - op_valid <= 1.
- If op_valid AND op_ready with no accept: op_valid <= 0. Data registers hold their values.
- If op_valid AND !op_ready: all op_* outputs hold stable.
- Scoreboard, per register r:
  - cleared if any wb_en[i] has wb_addr[i]==r.
  - set if accept with iss_vd_en and iss_vd==r.
  - set wins over clear in the same cycle.
  - multiple write ports to the same r is a legal clear.
- stall_cnt increments when iss_valid AND hazard. It saturates at 0xFFFF and never wraps.
- The block performs no data bypass. Correctness relies on the hazard stall.

## Timing
- Reset values:
  - iss_ready follows its equation (1 when iss_valid-independent conditions hold).
  - op_valid=0, op_data=0, op_vd=0, op_vd_en=0, op_uop=0.
  - sb_pending=0, stall_cnt=0.
- Issue-to-operand latency is 1 cycle: an accept at edge N gives op_valid high after edge N.
- Back-to-back throughput is 1 bundle/cycle when op_ready is held high and there are no hazards.
- Write-to-read: a VRF write with wb_en at edge N clears pending at N. The dependent issue is accepted no earlier than the cycle after edge N and captures the new data.
- A self-dependent op (vd equal to an enabled vs) with pending clear is accepted. It sets pending for vd and reads the old value.
- Reset asserted mid-operation clears every output and the scoreboard immediately. An in-flight bundle and pending-write tracking are discarded; upstream must flush.
- iss_valid must stay high with stable fields until accepted. op_valid never drops without op_ready.

## Test plan
- Reset, then issue vs1=3, vs2=4, src_en=3'b011, vd=5 with VRF r3=0xA..A, r4=0x5..5 -> next cycle op_valid=1, op_data[0]=0xA..A, op_data[1]=0x5..5, op_data[2]=0, sb_pending[5]=1.
- Issue with vd=5, then a dependent issue reading vs1=5 -> iss_ready=0 and stall_cnt increments each cycle. Then wb_en[2]=1 with wb_addr[2]=5 and new data 0x77..77 -> the issue is accepted the cycle after the write edge and op_data[0]=0x77..77.
- Same-cycle wb clear of r7 and issue with vd=7 (no prior pending) -> sb_pending[7]=1 after the edge (set wins).
- Hold op_ready=0 for 4 cycles with a second issue pending -> op_* stable, iss_ready=0. Raise op_ready -> second bundle replaces the first in the same cycle with no bubble.
- Force 70000 hazard cycles -> stall_cnt=0xFFFF, no wrap.
- Assert arst_n low while op_valid=1 and sb_pending=0x0000_0120 -> op_valid=0, sb_pending=0, stall_cnt=0 without a clock edge.

Source files
------------

// File: rtl/vrf_operand_fetch.sv
// Operand fetch on the VRF read side: issues reads, captures source vectors into a
// 1-cycle register slice, and stalls issue on RAW/WAW hazards via a per-register scoreboard.
module vrf_operand_fetch #(
   parameter int NUM_REG   = 32,
   parameter int DATA_SIZE = 2048,
   parameter int NUM_WB    = 8,
   parameter int UOP_W     = 32,
   parameter int ADDRESS   = $clog2(NUM_REG)
) (
   input  logic                             clk,
   input  logic                             arst_n,
   input  logic                             iss_valid,
   output logic                             iss_ready,
   input  logic [2:0][ADDRESS-1:0]          iss_vs,
   input  logic [2:0]                       iss_src_en,
   input  logic [ADDRESS-1:0]               iss_vd,
   input  logic                             iss_vd_en,
   input  logic [UOP_W-1:0]                 iss_uop,
   output logic [2:0][ADDRESS-1:0]          rd_addr,
   input  logic [2:0][DATA_SIZE-1:0]        rd_data,
   input  logic [NUM_WB-1:0]                wb_en,
   input  logic [NUM_WB-1:0][ADDRESS-1:0]   wb_addr,
   output logic                             op_valid,
   input  logic                             op_ready,
   output logic [2:0][DATA_SIZE-1:0]        op_data,
   output logic [ADDRESS-1:0]               op_vd,
   output logic                             op_vd_en,
   output logic [UOP_W-1:0]                 op_uop,
   output logic [NUM_REG-1:0]               sb_pending,
   output logic [15:0]                      stall_cnt
);

   logic                        op_valid_q;
   logic [2:0][DATA_SIZE-1:0]   op_data_q, op_data_d;
   logic [ADDRESS-1:0]          op_vd_q;
   logic                        op_vd_en_q;
   logic [UOP_W-1:0]            op_uop_q;
   logic [NUM_REG-1:0]          sb_q, sb_d;
   logic [15:0]                 stall_q, stall_d;
   logic                        hazard;
   logic                        accept;

   assign rd_addr = iss_vs;

   // Hazard looks only at the registered scoreboard; same-cycle clears still stall.
   always_comb begin
      hazard = iss_vd_en & sb_q[iss_vd];
      for (int k = 0; k < 3; k++) begin
         if (iss_src_en[k] && sb_q[iss_vs[k]]) hazard = 1'b1;
      end
   end

   assign iss_ready = !hazard && (!op_valid_q || op_ready);
   assign accept    = iss_valid && iss_ready;

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         op_data_d[k] = iss_src_en[k] ? rd_data[k] : '0;
      end
   end

   always_comb begin
      sb_d = sb_q;
      for (int i = 0; i < NUM_WB; i++) begin
         if (wb_en[i]) sb_d[wb_addr[i]] = 1'b0;
      end
      // Issue set is applied last so it wins over a coincident write-port clear.
      if (accept && iss_vd_en) sb_d[iss_vd] = 1'b1;
   end

   always_comb begin
      stall_d = stall_q;
      if (iss_valid && hazard && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         op_valid_q <= 1'b0;
         op_data_q  <= '0;
         op_vd_q    <= '0;
         op_vd_en_q <= 1'b0;
         op_uop_q   <= '0;
         sb_q       <= '0;
         stall_q    <= '0;
      end else begin
         sb_q    <= sb_d;
         stall_q <= stall_d;
         if (accept) begin
            op_valid_q <= 1'b1;
            op_data_q  <= op_data_d;
            op_vd_q    <= iss_vd;
            op_vd_en_q <= iss_vd_en;
            op_uop_q   <= iss_uop;
         end else if (op_ready) begin
            op_valid_q <= 1'b0;
         end
      end
   end

   assign op_valid   = op_valid_q;
   assign op_data    = op_data_q;
   assign op_vd      = op_vd_q;
   assign op_vd_en   = op_vd_en_q;
   assign op_uop     = op_uop_q;
   assign sb_pending = sb_q;
   assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_vrf_operand_fetch.sv
// Directed bench for vrf_operand_fetch with a behavioural VRF array driving rd_data.
module tb_vrf_operand_fetch;

   localparam int NUM_REG = 32;
   localparam int DS      = 2048;
   localparam int NUM_WB  = 8;
   localparam int UOP_W   = 32;
   localparam int AW      = 5;

   logic                        clk = 1'b0;
   logic                        arst_n;
   logic                        iss_valid;
   logic                        iss_ready;
   logic [2:0][AW-1:0]          iss_vs;
   logic [2:0]                  iss_src_en;
   logic [AW-1:0]               iss_vd;
   logic                        iss_vd_en;
   logic [UOP_W-1:0]            iss_uop;
   logic [2:0][AW-1:0]          rd_addr;
   logic [2:0][DS-1:0]          rd_data;
   logic [NUM_WB-1:0]           wb_en;
   logic [NUM_WB-1:0][AW-1:0]   wb_addr;
   logic                        op_valid;
   logic                        op_ready;
   logic [2:0][DS-1:0]          op_data;
   logic [AW-1:0]               op_vd;
   logic                        op_vd_en;
   logic [UOP_W-1:0]            op_uop;
   logic [NUM_REG-1:0]          sb_pending;
   logic [15:0]                 stall_cnt;

   logic [DS-1:0] vrf [NUM_REG];
   int total = 0;
   int bad   = 0;

   vrf_operand_fetch dut (
      .clk(clk), .arst_n(arst_n),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_vs(iss_vs),
      .iss_src_en(iss_src_en), .iss_vd(iss_vd), .iss_vd_en(iss_vd_en), .iss_uop(iss_uop),
      .rd_addr(rd_addr), .rd_data(rd_data), .wb_en(wb_en), .wb_addr(wb_addr),
      .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_vd(op_vd),
      .op_vd_en(op_vd_en), .op_uop(op_uop), .sb_pending(sb_pending), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < 3; k++) rd_data[k] = vrf[rd_addr[k]];
   end

   function automatic logic [DS-1:0] pat(input logic [7:0] b);
      return {(DS/8){b}};
   endfunction

   // Rotate-xor fold so wide vectors can be compared and printed in 64 bits.
   function automatic logic [63:0] fold(input logic [DS-1:0] v);
      logic [63:0] acc = '0;
      for (int i = 0; i < DS/64; i++) acc = {acc[62:0], acc[63]} ^ v[i*64 +: 64];
      return acc;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [AW-1:0] v0, input logic [AW-1:0] v1, input logic [AW-1:0] v2,
                        input logic [2:0] en, input logic [AW-1:0] vd, input logic vd_en,
                        input logic [UOP_W-1:0] uop);
      iss_valid  = 1'b1;
      iss_vs     = {v2, v1, v0};
      iss_src_en = en;
      iss_vd     = vd;
      iss_vd_en  = vd_en;
      iss_uop    = uop;
      #1;
   endtask

   initial begin
      for (int r = 0; r < NUM_REG; r++) vrf[r] = pat(8'(r));
      arst_n = 1'b0; iss_valid = 1'b0; iss_vs = '0; iss_src_en = '0;
      iss_vd = '0; iss_vd_en = 1'b0; iss_uop = '0; wb_en = '0; wb_addr = '0; op_ready = 1'b1;
      #2;
      check("rst_op_valid", 64'(op_valid), 64'd0);
      check("rst_sb", 64'(sb_pending), 64'd0);
      check("rst_stall", 64'(stall_cnt), 64'd0);
      check("rst_data0", fold(op_data[0]), 64'd0);
      check("rst_uop", 64'(op_uop), 64'd0);
      check("rst_iss_ready", 64'(iss_ready), 64'd1);
      @(negedge clk);
      arst_n = 1'b1;
      step();

      // Basic capture with source 2 masked off.
      vrf[3] = pat(8'hAA); vrf[4] = pat(8'h55); vrf[2] = pat(8'hEE);
      issue(5'd3, 5'd4, 5'd2, 3'b011, 5'd5, 1'b1, 32'h1111_0001);
      check("t1_rd_addr0", 64'(rd_addr[0]), 64'd3);
      check("t1_iss_ready", 64'(iss_ready), 64'd1);
      step();
      iss_valid = 1'b0;
      check("t1_op_valid", 64'(op_valid), 64'd1);
      check("t1_data0", fold(op_data[0]), fold(pat(8'hAA)));
      check("t1_data1", fold(op_data[1]), fold(pat(8'h55)));
      check("t1_data2", fold(op_data[2]), 64'd0);
      check("t1_sb", 64'(sb_pending), 64'h20);
      check("t1_vd", 64'(op_vd), 64'd5);
      check("t1_uop", 64'(op_uop), 64'h1111_0001);
      step();
      check("t1_drain", 64'(op_valid), 64'd0);

      // RAW stall on r5 until a write port clears it.
      issue(5'd5, 5'd0, 5'd0, 3'b001, 5'd9, 1'b1, 32'h2222_0002);
      check("t2_iss_ready_stall", 64'(iss_ready), 64'd0);
      repeat (3) step();
      check("t2_stall3", 64'(stall_cnt), 64'd3);
      check("t2_no_op", 64'(op_valid), 64'd0);
      vrf[5] = pat(8'h77);
      wb_en = 8'b0000_0100; wb_addr[2] = 5'd5;
      #1;
      check("t2_ready_at_wb", 64'(iss_ready), 64'd0);
      step();
      wb_en = '0;
      check("t2_sb_cleared", 64'(sb_pending), 64'd0);
      check("t2_stall4", 64'(stall_cnt), 64'd4);
      check("t2_ready_after_wb", 64'(iss_ready), 64'd1);
      step();
      iss_valid = 1'b0;
      check("t2_data0", fold(op_data[0]), fold(pat(8'h77)));
      check("t2_sb9", 64'(sb_pending), 64'h200);
      check("t2_vd", 64'(op_vd), 64'd9);

      // Same-cycle clear and set of r7 (two ports clear r7, one clears r9).
      issue(5'd0, 5'd0, 5'd0, 3'b000, 5'd7, 1'b1, 32'h3333_0003);
      wb_en = 8'b0000_1011; wb_addr[0] = 5'd7; wb_addr[1] = 5'd9; wb_addr[3] = 5'd7;
      step();
      iss_valid = 1'b0; wb_en = '0;
      check("t3_set_wins", 64'(sb_pending), 64'h80);
      wb_en[5] = 1'b1; wb_addr[5] = 5'd7;
      step();
      wb_en = '0;
      check("t3_cleared", 64'(sb_pending), 64'd0);
      check("t3_drain", 64'(op_valid), 64'd0);

      // Backpressure: first bundle holds, second replaces it with no bubble.
      op_ready = 1'b0;
      vrf[1] = pat(8'h11); vrf[2] = pat(8'h22);
      issue(5'd1, 5'd0, 5'd0, 3'b001, 5'd10, 1'b0, 32'hAAAA_000A);
      step();
      issue(5'd2, 5'd0, 5'd0, 3'b001, 5'd11, 1'b0, 32'hBBBB_000B);
      for (int c = 0; c < 4; c++) begin
         check("t4_hold_ready", 64'(iss_ready), 64'd0);
         check("t4_hold_valid", 64'(op_valid), 64'd1);
         check("t4_hold_uop", 64'(op_uop), 64'hAAAA_000A);
         check("t4_hold_data", fold(op_data[0]), fold(pat(8'h11)));
         step();
      end
      check("t4_no_stall_count", 64'(stall_cnt), 64'd4);
      op_ready = 1'b1;
      #1;
      check("t4_ready_comb", 64'(iss_ready), 64'd1);
      step();
      check("t4_swap_valid", 64'(op_valid), 64'd1);
      check("t4_swap_uop", 64'(op_uop), 64'hBBBB_000B);
      check("t4_swap_data", fold(op_data[0]), fold(pat(8'h22)));
      issue(5'd3, 5'd0, 5'd0, 3'b001, 5'd12, 1'b0, 32'hCCCC_000C);
      step();
      iss_valid = 1'b0;
      check("t4_b2b_uop", 64'(op_uop), 64'hCCCC_000C);
      check("t4_b2b_valid", 64'(op_valid), 64'd1);

      // Self-dependent op reads the old value and sets its own pending bit.
      vrf[6] = pat(8'h66);
      issue(5'd6, 5'd0, 5'd0, 3'b001, 5'd6, 1'b1, 32'h6666_0006);
      check("t6_ready", 64'(iss_ready), 64'd1);
      step();
      iss_valid = 1'b0;
      check("t6_data", fold(op_data[0]), fold(pat(8'h66)));
      check("t6_sb", 64'(sb_pending), 64'h40);
      wb_en[0] = 1'b1; wb_addr[0] = 5'd6;
      step();
      wb_en = '0;

      // Saturation of the stall counter on a long hazard on r12.
      issue(5'd0, 5'd0, 5'd0, 3'b000, 5'd12, 1'b1, 32'h0);
      step();
      check("t5_sb12", 64'(sb_pending), 64'h1000);
      issue(5'd12, 5'd0, 5'd0, 3'b001, 5'd0, 1'b0, 32'h0);
      repeat (65530) @(posedge clk);
      #1;
      check("t5_fffe", 64'(stall_cnt), 64'hFFFE);
      repeat (70000 - 65530) @(posedge clk);
      #1;
      check("t5_sat", 64'(stall_cnt), 64'hFFFF);
      iss_valid = 1'b0;
      wb_en[4] = 1'b1; wb_addr[4] = 5'd12;
      step();
      wb_en = '0;

      // Asynchronous reset mid-operation.
      issue(5'd0, 5'd0, 5'd0, 3'b000, 5'd5, 1'b1, 32'h5);
      step();
      issue(5'd0, 5'd0, 5'd0, 3'b000, 5'd8, 1'b1, 32'h8);
      step();
      iss_valid = 1'b0;
      check("t7_pre_sb", 64'(sb_pending), 64'h120);
      check("t7_pre_valid", 64'(op_valid), 64'd1);
      #2;
      arst_n = 1'b0;
      #1;
      check("t7_valid", 64'(op_valid), 64'd0);
      check("t7_sb", 64'(sb_pending), 64'd0);
      check("t7_stall", 64'(stall_cnt), 64'd0);
      check("t7_vd", 64'(op_vd), 64'd0);
      check("t7_uop", 64'(op_uop), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
